// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader placed in front of `computer`.
//
// Accepts an image as a byte stream (LEN_HI, LEN_LO, 4*N data bytes, CHK),
// packs the data bytes big-endian into n-bit instruction words, writes each
// word into the instruction memory and keeps the CPU in reset until the
// whole image has arrived and its XOR checksum matches.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   start        one-cycle pulse that begins a load (IDLE, RUN, ERROR only)
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     loader can accept a byte (LEN_HI, LEN_LO, DATA, CHECK)
//   imem_we      imem write strobe, one cycle per word
//   imem_addr    imem word address
//   imem_wdata   imem write data
//   cpu_reset    active-high reset to the CPU, low only in RUN
//   done         image loaded and verified, CPU running
//   error        load failed (oversize length or bad checksum)
//   words_loaded number of words written during the current load
module prog_loader #(
    parameter int n  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [n-1:0]  imem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   len;
    logic [1:0]    byte_cnt;
    logic [7:0]    xor_acc;
    logic [n-9:0]  word_reg;   // first three bytes of the word being assembled

    logic          accept;
    logic          start_ok;
    logic [15:0]   len_full;
    logic          last_byte;
    logic          last_word;

    assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CHECK);
    assign accept    = in_valid && in_ready;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_RUN) ||
                                 (state == S_ERROR));
    // Length as it stands while the low byte is on the bus.
    assign len_full  = {len[15:8], in_data};
    assign last_byte = (byte_cnt == 2'd3);
    // words_loaded doubles as the index of the word being assembled.
    assign last_word = (words_loaded == len - 16'd1);

    assign cpu_reset = (state != S_RUN);
    assign done      = (state == S_RUN);
    assign error     = (state == S_ERROR);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned; a missing default in always_comb infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (32'(len_full) > DEPTH) begin
                        state_nxt = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA:   if (accept && last_byte && last_word) state_nxt = S_CHECK;
            S_CHECK: begin
                if (accept) begin
                    state_nxt = (in_data == xor_acc) ? S_RUN : S_ERROR;
                end
            end
            S_RUN, S_ERROR: if (start) state_nxt = S_LEN_HI;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the word assembly register is reset along with the rest; it is a
    // handful of flops, not a memory array, so the reset costs nothing real.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len          <= '0;
            byte_cnt     <= '0;
            xor_acc      <= '0;
            word_reg     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                len          <= '0;
                byte_cnt     <= '0;
                xor_acc      <= '0;
                words_loaded <= '0;
            end else if (accept) begin
                // Also folds in the CHK byte; harmless, the load ends there.
                xor_acc <= xor_acc ^ in_data;
                case (state)
                    S_LEN_HI: len[15:8] <= in_data;
                    S_LEN_LO: len[7:0]  <= in_data;
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            // Launch the write straight from the bus byte so the
                            // next word's first byte can land on the next edge.
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[AW-1:0];
                            imem_wdata   <= {word_reg, in_data};
                            words_loaded <= words_loaded + 16'd1;
                        end else begin
                            word_reg <= {word_reg[n-17:0], in_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus random images,
// compared against an image-level reference model.
module tb_prog_loader;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    prog_loader #(.n(32), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]    stream[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    bit            exp_run;
    int            exp_words;
    int            consumed;

    // Record every write pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what the image should do, judged from its bytes alone.
    task automatic model();
        int nw;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        nw = int'({stream[0], stream[1]});
        if (nw > 2 ** AW) begin
            exp_run   = 1'b0;
            exp_words = 0;
            consumed  = 2;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * nw; i++) x = x ^ stream[i];
        for (int k = 0; k < nw; k++) begin
            exp_addr.push_back(AW'(k));
            exp_data.push_back({stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]});
        end
        exp_words = nw;
        consumed  = 3 + 4 * nw;
        exp_run   = (stream[2+4*nw] == x);
    endtask

    task automatic build_stream(input int nw, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(nw >> 8));
        stream.push_back(8'(nw));
        x = 8'(nw >> 8) ^ 8'(nw);
        for (int i = 0; i < 4 * nw; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        stream.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        in_data  = b;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            r = in_ready;
            tick();
            if (r) return;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_imem_we"}, imem_we, 1'b0);
        check({tag, "_imem_addr"}, imem_addr, '0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'h0);
        check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_words_loaded"}, words_loaded, 16'd0);
    endtask

    task automatic run_load(input string name, input bit gapped, input bit mid_start);
        int k;
        pulse_start();
        check({name, "_start_cpu_reset"}, cpu_reset, 1'b1);
        check({name, "_start_done"}, done, 1'b0);
        check({name, "_start_words"}, words_loaded, 16'd0);
        got_addr.delete();
        got_data.delete();
        model();
        for (int i = 0; i < consumed; i++) begin
            if (gapped) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            if (mid_start && i == 4) begin
                in_valid = 1'b0;
                pulse_start();
            end
            send_byte(stream[i]);
            if (i >= 2 && i < 2 + 4 * exp_data.size() && (i - 2) % 4 == 3) begin
                k = (i - 2) / 4;
                check({name, "_we_pulse"}, imem_we, 1'b1);
                check({name, "_we_addr"}, imem_addr, exp_addr[k]);
                check({name, "_we_data"}, imem_wdata, exp_data[k]);
            end
        end
        in_valid = 1'b0;
        check({name, "_done"}, done, exp_run);
        check({name, "_error"}, error, !exp_run);
        check({name, "_cpu_reset"}, cpu_reset, !exp_run);
        check({name, "_in_ready"}, in_ready, 1'b0);
        check({name, "_words_loaded"}, words_loaded, 16'(exp_words));
        repeat (3) tick();
        check({name, "_write_count"}, 64'(got_data.size()), 64'(exp_data.size()));
        for (int j = 0; j < exp_data.size(); j++) begin
            if (j < got_data.size()) begin
                check({name, "_wr_addr"}, got_addr[j], exp_addr[j]);
                check({name, "_wr_data"}, got_data[j], exp_data[j]);
            end
        end
        check({name, "_done_hold"}, done, exp_run);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic load.
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h54, 8'hDF};
        run_load("basic", 1'b0, 1'b0);

        // Bad checksum.
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h54, 8'hDE};
        run_load("badchk", 1'b0, 1'b0);

        // One word past capacity.
        stream = '{8'h00, 8'h41, 8'h00};
        run_load("oversize", 1'b0, 1'b0);

        // Empty image.
        stream = '{8'h00, 8'h00, 8'h00};
        run_load("empty", 1'b0, 1'b0);

        // Gapped valid with a start pulse mid-DATA.
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h54, 8'hDF};
        run_load("gapped", 1'b1, 1'b1);

        // Asynchronous reset after six bytes.
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i]);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #2;
        reset = 1'b1;
        tick();
        run_load("after_rst", 1'b0, 1'b0);

        // Reload from RUN with a single zero word.
        stream = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        run_load("reload", 1'b0, 1'b0);

        // Full-depth image.
        build_stream(2 ** AW, 1'b0);
        run_load("full_depth", 1'b0, 1'b0);

        // Random images, some with a corrupted checksum.
        for (int t = 0; t < 8; t++) begin
            build_stream(int'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0));
            run_load("random", ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
